// File: rtl/payload_rx.sv
`default_nettype none
// payload_rx: three-beat 80-byte order/execution message parser on a 256-bit AXI-Stream link.
// Optional statistics counters are built when PAYLOAD_RX_STATS_EN is defined. Rev 1.0
module payload_rx #(
  parameter logic [15:0] EXP_LENGTH  = 16'd77,
  parameter logic [7:0]  EXP_MSGTYPE = 8'd101
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [255:0] s_tdata,
  input  logic [31:0]  s_tkeep,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic         out_valid,
  output logic [15:0]  msg_length,
  output logic [31:0]  MsgSeqNum,
  output logic [31:0]  epoch_s,
  output logic [15:0]  ms,
  output logic [7:0]   MessageType,
  output logic [15:0]  hdr_fcm_id,
  output logic [15:0]  session_id,
  output logic [7:0]   ExecType,
  output logic [15:0]  cm_id,
  output logic [15:0]  fcm_id,
  output logic [39:0]  order_no,
  output logic [31:0]  ord_id,
  output logic [63:0]  user_define,
  output logic [7:0]   symbol_type,
  output logic [159:0] sym,
  output logic [31:0]  price,
  output logic [15:0]  qty,
  output logic [31:0]  investor_acno,
  output logic [7:0]   investor_flag,
  output logic [7:0]   side,
  output logic [7:0]   OrdType,
  output logic [7:0]   TimeInForce,
  output logic [7:0]   PositionEffect,
  output logic [7:0]   order_source,
  output logic [23:0]  info_source,
  output logic         err_framing,
  output logic         err_length,
  output logic         err_type,
  output logic         err_checksum,
  output logic [31:0]  good_cnt,
  output logic [31:0]  err_cnt
);

  localparam logic [1:0] S_B0   = 2'd0;
  localparam logic [1:0] S_B1   = 2'd1;
  localparam logic [1:0] S_B2   = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]   r_state;
  logic         r_ready;
  logic [511:0] r_hold;
  logic [15:0]  r_sum;
  logic         r_kerr;
  logic [639:8] r_frame;
  logic         r_valid, r_efrm, r_elen, r_etyp, r_eck;

  logic         w_accept;
  logic [15:0]  w_sum_lo, w_sum_hi, w_beat_sum, w_total;
  logic [639:0] w_rev;
  logic [1:0]   w_nxt_state;
  logic         w_p_valid, w_p_frm, w_p_len, w_p_typ, w_p_ck;

  assign w_accept = s_tvalid & r_ready;

  // Bytes 0-14 of the final beat are the last checksummed bytes; byte 15 is the checksum itself.
  always_comb begin
    w_sum_lo = '0;
    w_sum_hi = '0;
    for (int i = 0; i < 15; i++) w_sum_lo = w_sum_lo + {8'd0, s_tdata[8*i +: 8]};
    for (int i = 15; i < 32; i++) w_sum_hi = w_sum_hi + {8'd0, s_tdata[8*i +: 8]};
    w_beat_sum = w_sum_lo + w_sum_hi;
    w_total    = r_sum + w_sum_lo;
  end

  // Byte-reversed message: every big-endian field becomes one contiguous slice.
  for (genvar k = 0; k < 80; k++) begin : g_rev
    if (k < 64) begin : g_hold
      assign w_rev[8*(79-k) +: 8] = r_hold[8*k +: 8];
    end else begin : g_beat2
      assign w_rev[8*(79-k) +: 8] = s_tdata[8*(k-64) +: 8];
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_p_valid   = 1'b0;
    w_p_frm     = 1'b0;
    w_p_len     = 1'b0;
    w_p_typ     = 1'b0;
    w_p_ck      = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_B0: begin
          if (s_tlast) w_p_frm = 1'b1;
          else         w_nxt_state = S_B1;
        end
        S_B1: begin
          if (s_tlast) begin
            w_p_frm     = 1'b1;
            w_nxt_state = S_B0;
          end else begin
            w_nxt_state = S_B2;
          end
        end
        S_B2: begin
          if (!s_tlast) begin
            w_p_frm     = 1'b1;
            w_nxt_state = S_DROP;
          end else begin
            w_nxt_state = S_B0;
            if (r_kerr || !(&s_tkeep[15:0])) w_p_frm = 1'b1;
            else if (w_rev[639:624] != EXP_LENGTH) w_p_len = 1'b1;
            else if (w_rev[543:536] != EXP_MSGTYPE) w_p_typ = 1'b1;
            else if (w_total[7:0] != w_rev[7:0]) w_p_ck = 1'b1;
            else w_p_valid = 1'b1;
          end
        end
        default: begin
          if (s_tlast) w_nxt_state = S_B0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_B0;
      r_ready <= 1'b0;
      r_hold  <= '0;
      r_sum   <= '0;
      r_kerr  <= 1'b0;
      r_frame <= '0;
      r_valid <= 1'b0;
      r_efrm  <= 1'b0;
      r_elen  <= 1'b0;
      r_etyp  <= 1'b0;
      r_eck   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_state <= w_nxt_state;
      r_valid <= w_p_valid;
      r_efrm  <= w_p_frm;
      r_elen  <= w_p_len;
      r_etyp  <= w_p_typ;
      r_eck   <= w_p_ck;
      if (w_accept && r_state == S_B0) begin
        r_hold[255:0] <= s_tdata;
        r_sum         <= w_beat_sum;
        r_kerr        <= ~(&s_tkeep);
      end
      if (w_accept && r_state == S_B1) begin
        r_hold[511:256] <= s_tdata;
        r_sum           <= r_sum + w_beat_sum;
        r_kerr          <= r_kerr | ~(&s_tkeep);
      end
      if (w_p_valid) r_frame <= w_rev[639:8];
    end
  end

`ifdef PAYLOAD_RX_STATS_EN
  logic [31:0] r_good_cnt;
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_p_valid) r_good_cnt <= r_good_cnt + 32'd1;
      if (w_p_frm | w_p_len | w_p_typ | w_p_ck) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign good_cnt = r_good_cnt;
  assign err_cnt  = r_err_cnt;
`else
  assign good_cnt = '0;
  assign err_cnt  = '0;
`endif

  assign s_tready       = r_ready;
  assign out_valid      = r_valid;
  assign err_framing    = r_efrm;
  assign err_length     = r_elen;
  assign err_type       = r_etyp;
  assign err_checksum   = r_eck;
  assign msg_length     = r_frame[639:624];
  assign MsgSeqNum      = r_frame[623:592];
  assign epoch_s        = r_frame[591:560];
  assign ms             = r_frame[559:544];
  assign MessageType    = r_frame[543:536];
  assign hdr_fcm_id     = r_frame[535:520];
  assign session_id     = r_frame[519:504];
  assign ExecType       = r_frame[503:496];
  assign cm_id          = r_frame[495:480];
  assign fcm_id         = r_frame[479:464];
  assign order_no       = r_frame[463:424];
  assign ord_id         = r_frame[423:392];
  assign user_define    = r_frame[391:328];
  assign symbol_type    = r_frame[327:320];
  assign sym            = r_frame[319:160];
  assign price          = r_frame[159:128];
  assign qty            = r_frame[127:112];
  assign investor_acno  = r_frame[111:80];
  assign investor_flag  = r_frame[79:72];
  assign side           = r_frame[71:64];
  assign OrdType        = r_frame[63:56];
  assign TimeInForce    = r_frame[55:48];
  assign PositionEffect = r_frame[47:40];
  assign order_source   = r_frame[39:32];
  assign info_source    = r_frame[31:8];

endmodule
`default_nettype wire

// File: tb/tb_payload_rx.sv
`default_nettype none
// tb_payload_rx: randomized frames checked against a byte-array reference model. Rev 1.0
module tb_payload_rx;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_GOOD = 5'b10000;
  localparam logic [4:0] P_FRM  = 5'b01000;
  localparam logic [4:0] P_LEN  = 5'b00100;
  localparam logic [4:0] P_TYP  = 5'b00010;
  localparam logic [4:0] P_CK   = 5'b00001;
`ifdef PAYLOAD_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         s_tvalid, s_tlast, s_tready, out_valid;
  logic [15:0]  msg_length, ms, hdr_fcm_id, session_id, cm_id, fcm_id, qty;
  logic [31:0]  MsgSeqNum, epoch_s, ord_id, price, investor_acno, good_cnt, err_cnt;
  logic [7:0]   MessageType, ExecType, symbol_type, investor_flag, side, OrdType;
  logic [7:0]   TimeInForce, PositionEffect, order_source;
  logic [39:0]  order_no;
  logic [63:0]  user_define;
  logic [159:0] sym;
  logic [23:0]  info_source;
  logic         err_framing, err_length, err_type, err_checksum;

  payload_rx dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .out_valid(out_valid),
    .msg_length(msg_length), .MsgSeqNum(MsgSeqNum), .epoch_s(epoch_s), .ms(ms),
    .MessageType(MessageType), .hdr_fcm_id(hdr_fcm_id), .session_id(session_id),
    .ExecType(ExecType), .cm_id(cm_id), .fcm_id(fcm_id), .order_no(order_no),
    .ord_id(ord_id), .user_define(user_define), .symbol_type(symbol_type), .sym(sym),
    .price(price), .qty(qty), .investor_acno(investor_acno), .investor_flag(investor_flag),
    .side(side), .OrdType(OrdType), .TimeInForce(TimeInForce),
    .PositionEffect(PositionEffect), .order_source(order_source), .info_source(info_source),
    .err_framing(err_framing), .err_length(err_length), .err_type(err_type),
    .err_checksum(err_checksum), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_good = 0;
  int unsigned exp_err  = 0;
  logic [7:0]  f_bytes   [80];
  logic [7:0]  exp_bytes [80];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Big-endian field of n bytes starting at message byte a of the last good frame.
  function automatic logic [159:0] be(input int a, input int n);
    logic [159:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[151:0], exp_bytes[a+i]};
    return r;
  endfunction

  function automatic logic [4:0] pulses();
    return {out_valid, err_framing, err_length, err_type, err_checksum};
  endfunction

  task automatic check_fields();
    chk("msg_length",     160'(msg_length),     be(0, 2));
    chk("MsgSeqNum",      160'(MsgSeqNum),      be(2, 4));
    chk("epoch_s",        160'(epoch_s),        be(6, 4));
    chk("ms",             160'(ms),             be(10, 2));
    chk("MessageType",    160'(MessageType),    be(12, 1));
    chk("hdr_fcm_id",     160'(hdr_fcm_id),     be(13, 2));
    chk("session_id",     160'(session_id),     be(15, 2));
    chk("ExecType",       160'(ExecType),       be(17, 1));
    chk("cm_id",          160'(cm_id),          be(18, 2));
    chk("fcm_id",         160'(fcm_id),         be(20, 2));
    chk("order_no",       160'(order_no),       be(22, 5));
    chk("ord_id",         160'(ord_id),         be(27, 4));
    chk("user_define",    160'(user_define),    be(31, 8));
    chk("symbol_type",    160'(symbol_type),    be(39, 1));
    chk("sym",            sym,                  be(40, 20));
    chk("price",          160'(price),          be(60, 4));
    chk("qty",            160'(qty),            be(64, 2));
    chk("investor_acno",  160'(investor_acno),  be(66, 4));
    chk("investor_flag",  160'(investor_flag),  be(70, 1));
    chk("side",           160'(side),           be(71, 1));
    chk("OrdType",        160'(OrdType),        be(72, 1));
    chk("TimeInForce",    160'(TimeInForce),    be(73, 1));
    chk("PositionEffect", 160'(PositionEffect), be(74, 1));
    chk("order_source",   160'(order_source),   be(75, 1));
    chk("info_source",    160'(info_source),    be(76, 3));
  endtask

  task automatic check_cnts();
    chk("good_cnt", 160'(good_cnt), STATS ? 160'(exp_good) : 160'd0);
    chk("err_cnt",  160'(err_cnt),  STATS ? 160'(exp_err)  : 160'd0);
  endtask

  // Outcome of a correctly framed frame, from the message rules alone.
  function automatic logic [4:0] eval_content();
    int s = 0;
    for (int i = 0; i < 79; i++) s += int'(f_bytes[i]);
    if ({f_bytes[0], f_bytes[1]} != 16'd77) return P_LEN;
    if (f_bytes[12] != 8'd101) return P_TYP;
    if (8'(s) != f_bytes[79]) return P_CK;
    return P_GOOD;
  endfunction

  task automatic fix_ck();
    int s = 0;
    for (int i = 0; i < 79; i++) s += int'(f_bytes[i]);
    f_bytes[79] = 8'(s);
  endtask

  task automatic make_good();
    for (int i = 0; i < 80; i++) f_bytes[i] = 8'($urandom);
    f_bytes[0]  = 8'd0;
    f_bytes[1]  = 8'd77;
    f_bytes[12] = 8'd101;
    fix_ck();
  endtask

  task automatic drive_beat(input int j, input bit last, input logic [31:0] keep,
                            input logic [4:0] exp_p, input string tag);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) begin
      if (j < 3 && 32*j + k < 80) d[8*k +: 8] = f_bytes[32*j + k];
      else                        d[8*k +: 8] = 8'($urandom);
    end
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    chk(tag, 160'(pulses()), 160'(exp_p));
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'($urandom);
    s_tdata  = {8{$urandom}};
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle_pulse", 160'(pulses()), 160'(P_NONE));
    end
  endtask

  // last_at: index of the tlast beat; bad_keep: beat with a cleared keep bit (-1 none).
  task automatic send_frame(input int last_at, input int bad_keep, input bit gaps);
    logic [31:0] keep;
    logic [4:0]  exp_p;
    for (int j = 0; j <= last_at; j++) begin
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 2));
      keep = '1;
      if (j == bad_keep) keep[(j == 2) ? $urandom_range(15) : $urandom_range(31)] = 1'b0;
      exp_p = P_NONE;
      if (j == last_at && last_at < 2) exp_p = P_FRM;
      else if (j == 2 && last_at > 2) exp_p = P_FRM;
      else if (j == 2 && last_at == 2) exp_p = (bad_keep >= 0 && bad_keep <= 2) ? P_FRM : eval_content();
      drive_beat(j, j == last_at, keep, exp_p, "pulse");
      if (exp_p == P_GOOD) begin
        exp_bytes = f_bytes;
        exp_good++;
      end else if (exp_p != P_NONE) begin
        exp_err++;
      end
      if (exp_p != P_NONE) begin
        check_fields();
        check_cnts();
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tready"}, 160'(s_tready), 160'd0);
    chk({tag, "_pulses"}, 160'(pulses()), 160'(P_NONE));
    check_fields();
    check_cnts();
  endtask

  initial begin
    int v;
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = '0;
    s_tdata  = '0;
    for (int i = 0; i < 80; i++) exp_bytes[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_up", 160'(s_tready), 160'd1);

    for (int i = 0; i < 80; i++) f_bytes[i] = 8'd0;
    f_bytes[1] = 8'h4D; f_bytes[12] = 8'd101; f_bytes[14] = 8'hED; f_bytes[21] = 8'hED;
    f_bytes[70] = 8'd79; f_bytes[76] = 8'd57; f_bytes[77] = 8'd57; f_bytes[78] = 8'd57;
    f_bytes[79] = 8'h86;
    send_frame(2, -1, 1'b0);
    chk("plan_len",  160'(msg_length), 160'd77);
    chk("plan_fcm",  160'(fcm_id), 160'd237);
    chk("plan_info", 160'(info_source), 160'h393939);
    chk("plan_gcnt", 160'(good_cnt), STATS ? 160'd1 : 160'd0);
    f_bytes[79] = 8'h87;
    send_frame(2, -1, 1'b0);

    make_good(); send_frame(1, -1, 1'b0);
    make_good(); send_frame(2, -1, 1'b0);
    make_good(); send_frame(3, -1, 1'b0);
    make_good(); send_frame(2, -1, 1'b0);
    make_good(); f_bytes[1] = 8'd78; f_bytes[79] = f_bytes[79] ^ 8'h01; send_frame(2, -1, 1'b0);
    make_good(); f_bytes[12] = 8'd102; fix_ck(); send_frame(2, -1, 1'b0);
    make_good(); send_frame(0, -1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      make_good(); send_frame(2, b, 1'b0);
    end

    for (int n = 0; n < 250; n++) begin
      make_good();
      case ($urandom_range(7))
        0, 1: send_frame(2, -1, 1'($urandom));
        2: begin f_bytes[79] = f_bytes[79] ^ 8'($urandom_range(1, 255)); send_frame(2, -1, 1'($urandom)); end
        3: begin
          v = $urandom_range(0, 65535);
          if (v == 77) v = 78;
          {f_bytes[0], f_bytes[1]} = 16'(v);
          if ($urandom_range(1) == 0) fix_ck();
          send_frame(2, -1, 1'($urandom));
        end
        4: begin
          f_bytes[12] = 8'($urandom_range(0, 255));
          if (f_bytes[12] == 8'd101) f_bytes[12] = 8'd0;
          fix_ck();
          send_frame(2, -1, 1'($urandom));
        end
        5: send_frame($urandom_range(0, 1), -1, 1'($urandom));
        6: send_frame($urandom_range(3, 5), -1, 1'($urandom));
        default: send_frame(2, $urandom_range(0, 2), 1'($urandom));
      endcase
      if ($urandom_range(4) == 0) idle(1);
    end

    make_good();
    drive_beat(0, 1'b0, '1, P_NONE, "rst_b0");
    drive_beat(1, 1'b0, '1, P_NONE, "rst_b1");
    #2;
    resetn = 1'b0;
    for (int i = 0; i < 80; i++) exp_bytes[i] = 8'd0;
    exp_good = 0;
    exp_err  = 0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_again", 160'(s_tready), 160'd1);
    make_good();
    f_bytes[2] = 8'h01; f_bytes[3] = 8'h02; f_bytes[4] = 8'h03; f_bytes[5] = 8'h04;
    fix_ck();
    send_frame(2, -1, 1'b0);
    chk("seq_after_rst",  160'(MsgSeqNum), 160'h01020304);
    chk("gcnt_after_rst", 160'(good_cnt), STATS ? 160'd1 : 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
